// File: rtl/apb4_mst.sv
// apb4_mst: single-outstanding APB4 requester bridging a valid/ready request/response pair to APB4.
// One transfer at a time, with optional ACCESS-phase timeout and misalignment rejection.
module apb4_mst #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_strb_i,
  input  logic [2:0]              req_prot_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [2:0]              pprot_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic                    pready_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pslverr_i
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] strb_q, strb_d;
  logic [2:0]              prot_q, prot_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      prot_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      prot_q  <= prot_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    prot_d  = prot_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE:
        if (req_valid_i) begin
          if (req_addr_i[1:0] == 2'b00) begin
            write_d = req_write_i;
            addr_d  = req_addr_i;
            wdata_d = req_wdata_i;
            strb_d  = req_strb_i;
            prot_d  = req_prot_i;
            state_d = SETUP;
          end else begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS:
        if (pready_i) begin
          rdata_d = write_q ? '0 : prdata_i;
          err_d   = pslverr_i;
          state_d = RESP;
        end else if (TIMEOUT != 0 && cnt_q == LIMIT) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      RESP:
        if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign req_ready_o = state_q == IDLE;
  assign psel_o      = state_q == SETUP || state_q == ACCESS;
  assign penable_o   = state_q == ACCESS;
  assign rsp_valid_o = state_q == RESP;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign paddr_o     = addr_q;
  assign pprot_o     = prot_q;
  assign pwrite_o    = write_q;
  assign pwdata_o    = wdata_q;
  assign pstrb_o     = write_q ? strb_q : '0;
endmodule
